// File: rtl/bus_arbiter_mux_if.sv
// Bus-source arbitration bundle: per-source requests and data in, registered bus and grant out.
// Handshake: a source holding src_req[i] high is granted when grant[i]/bus_valid rise; there is no ready, the grant itself is the acknowledge.
interface bus_arbiter_mux_if #(
  parameter int N_SRC = 32,
  parameter int WIDTH = 32,
  parameter int IDX_W = $clog2(N_SRC)
);
  logic [N_SRC*WIDTH-1:0] src_data;
  logic [N_SRC-1:0]       src_req;
  logic                   bus_lock;
  logic                   conf_clr;
  logic [WIDTH-1:0]       bus_out;
  logic                   bus_valid;
  logic [N_SRC-1:0]       grant;
  logic [IDX_W-1:0]       grant_idx;
  logic                   conflict;
  logic [15:0]            conflict_cnt;
  logic [IDX_W-1:0]       dbgPtr;

  modport master (
    output src_data, src_req, bus_lock, conf_clr,
    input  bus_out, bus_valid, grant, grant_idx, conflict, conflict_cnt, dbgPtr
  );

  modport slave (
    input  src_data, src_req, bus_lock, conf_clr,
    output bus_out, bus_valid, grant, grant_idx, conflict, conflict_cnt, dbgPtr
  );
endinterface

// File: rtl/bus_arbiter_mux.sv
// Registered request/grant selector for the datapath bus with fixed-priority or round-robin policy,
// bus locking and a saturating multi-driver conflict counter.
module bus_arbiter_mux #(
  parameter int N_SRC     = 32,
  parameter int WIDTH     = 32,
  parameter int RR_MODE   = 0,
  parameter int HOLD_IDLE = 0
) (
  input logic             clock,
  input logic             clear,
  bus_arbiter_mux_if.slave bus
);
  localparam int IDX_W = $clog2(N_SRC);

  logic [IDX_W-1:0] ptr;
  logic [IDX_W-1:0] winner;
  logic [N_SRC-1:0] reqMasked;
  logic             locked;
  logic             anyReq;
  logic             multiReq;

  function automatic logic [IDX_W-1:0] lowestIdx(input logic [N_SRC-1:0] v);
    lowestIdx = '0;
    for (int i = N_SRC - 1; i >= 0; i--) begin
      if (v[i]) lowestIdx = IDX_W'(i);
    end
  endfunction

  assign anyReq   = |bus.src_req;
  // Clearing the lowest set bit leaves something only when two or more bits were set.
  assign multiReq = |(bus.src_req & (bus.src_req - N_SRC'(1)));
  assign bus.dbgPtr = ptr;

  always_comb begin
    reqMasked = '0;
    for (int i = 0; i < N_SRC; i++) begin
      reqMasked[i] = bus.src_req[i] && (i >= int'(ptr));
    end
    locked = bus.bus_lock && bus.bus_valid && bus.src_req[bus.grant_idx];
    // Round-robin: search from ptr upward first, wrap to the plain lowest request otherwise.
    if (locked)
      winner = bus.grant_idx;
    else if (RR_MODE != 0 && |reqMasked)
      winner = lowestIdx(reqMasked);
    else
      winner = lowestIdx(bus.src_req);
  end

  always_ff @(posedge clock) begin
    if (clear) begin
      bus.bus_out      <= '0;
      bus.bus_valid    <= 1'b0;
      bus.grant        <= '0;
      bus.grant_idx    <= '0;
      bus.conflict     <= 1'b0;
      bus.conflict_cnt <= '0;
      ptr              <= '0;
    end else begin
      if (anyReq) begin
        bus.bus_valid <= 1'b1;
        bus.grant     <= N_SRC'(1) << winner;
        bus.grant_idx <= winner;
        bus.bus_out   <= bus.src_data[int'(winner)*WIDTH +: WIDTH];
        if (RR_MODE != 0 && !locked)
          ptr <= (int'(winner) == N_SRC - 1) ? '0 : winner + IDX_W'(1);
      end else begin
        bus.bus_valid <= 1'b0;
        bus.grant     <= '0;
        bus.grant_idx <= '0;
        if (HOLD_IDLE == 0) bus.bus_out <= '0;
      end

      if (bus.conf_clr) begin
        bus.conflict     <= 1'b0;
        bus.conflict_cnt <= '0;
      end else if (multiReq) begin
        bus.conflict <= 1'b1;
        if (bus.conflict_cnt != 16'hFFFF) bus.conflict_cnt <= bus.conflict_cnt + 16'd1;
      end
    end
  end
endmodule

// File: tb/tb_bus_arbiter_mux.sv
// Drives a 32-source fixed-priority/zeroing instance and a 4-source round-robin/holding instance
// with shared stimulus and checks both against a behavioural model.
module tb_bus_arbiter_mux;
  logic          clock;
  logic          clear;
  logic [31:0]   req;
  logic [1023:0] data;
  logic          lock;
  logic          cclr;
  logic          checkEn;
  int            checks;
  int            failures;

  // Reference model state, index 0 = instance A, 1 = instance B.
  logic          expValid[2];
  int            expIdx[2];
  logic [31:0]   expBus[2];
  int            expCnt[2];
  logic          expConf[2];
  int            expPtr[2];

  bus_arbiter_mux_if #(.N_SRC(32), .WIDTH(32)) ifA ();
  bus_arbiter_mux_if #(.N_SRC(4),  .WIDTH(32)) ifB ();

  bus_arbiter_mux #(.N_SRC(32), .WIDTH(32), .RR_MODE(0), .HOLD_IDLE(0)) dutA (
    .clock(clock), .clear(clear), .bus(ifA.slave));
  bus_arbiter_mux #(.N_SRC(4), .WIDTH(32), .RR_MODE(1), .HOLD_IDLE(1)) dutB (
    .clock(clock), .clear(clear), .bus(ifB.slave));

  assign ifA.src_req  = req;
  assign ifA.src_data = data;
  assign ifA.bus_lock = lock;
  assign ifA.conf_clr = cclr;
  assign ifB.src_req  = req[3:0];
  assign ifB.src_data = data[127:0];
  assign ifB.bus_lock = lock;
  assign ifB.conf_clr = cclr;

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic modelStep(input int d, input int n, input bit rr, input bit hold);
    int owner;
    int nreq;
    int j;
    if (clear) begin
      expValid[d] = 1'b0; expIdx[d] = 0; expBus[d] = '0;
      expCnt[d] = 0; expConf[d] = 1'b0; expPtr[d] = 0;
      return;
    end
    nreq = 0;
    for (int i = 0; i < n; i++) if (req[i]) nreq++;
    owner = -1;
    if (lock && expValid[d] && req[expIdx[d]]) begin
      owner = expIdx[d];
    end else begin
      for (int k = 0; k < n; k++) begin
        j = rr ? (expPtr[d] + k) % n : k;
        if (owner < 0 && req[j]) owner = j;
      end
      if (rr && owner >= 0) expPtr[d] = (owner + 1) % n;
    end
    if (owner >= 0) begin
      expValid[d] = 1'b1; expIdx[d] = owner; expBus[d] = data[owner*32 +: 32];
    end else begin
      expValid[d] = 1'b0; expIdx[d] = 0;
      if (!hold) expBus[d] = '0;
    end
    if (cclr) begin
      expCnt[d] = 0; expConf[d] = 1'b0;
    end else if (nreq >= 2) begin
      expConf[d] = 1'b1;
      if (expCnt[d] < 65535) expCnt[d]++;
    end
  endtask

  task automatic step();
    @(posedge clock);
    modelStep(0, 32, 1'b0, 1'b0);
    modelStep(1, 4, 1'b1, 1'b1);
    #1;
    if (checkEn) begin
      chk("a_valid", 32'(ifA.bus_valid), 32'(expValid[0]));
      chk("a_grant", ifA.grant, expValid[0] ? (32'h1 << expIdx[0]) : 32'h0);
      chk("a_idx", 32'(ifA.grant_idx), 32'(expIdx[0]));
      chk("a_bus", ifA.bus_out, expBus[0]);
      chk("a_conf", 32'(ifA.conflict), 32'(expConf[0]));
      chk("a_cnt", 32'(ifA.conflict_cnt), 32'(expCnt[0]));
      chk("b_valid", 32'(ifB.bus_valid), 32'(expValid[1]));
      chk("b_grant", 32'(ifB.grant), expValid[1] ? (32'h1 << expIdx[1]) : 32'h0);
      chk("b_idx", 32'(ifB.grant_idx), 32'(expIdx[1]));
      chk("b_bus", ifB.bus_out, expBus[1]);
      chk("b_conf", 32'(ifB.conflict), 32'(expConf[1]));
      chk("b_cnt", 32'(ifB.conflict_cnt), 32'(expCnt[1]));
      chk("b_ptr", 32'(ifB.dbgPtr), 32'(expPtr[1]));
    end
  endtask

  initial begin
    int rrSeq[6];
    int r;
    rrSeq = '{0, 1, 3, 0, 1, 3};
    checks = 0; failures = 0; checkEn = 1'b1;
    lock = 1'b0; cclr = 1'b0;
    for (int i = 0; i < 32; i++) data[i*32 +: 32] = $urandom();

    // Reset under full request load, then fresh arbitration.
    clear = 1'b1; req = 32'hFFFF_FFFF;
    step(); step();
    chk("rst_a_cnt", 32'(ifA.conflict_cnt), 32'h0);
    chk("rst_b_bus", ifB.bus_out, 32'h0);
    clear = 1'b0;
    step();
    chk("rst_a_first", 32'(ifA.grant_idx), 32'd0);
    chk("rst_b_first", 32'(ifB.grant_idx), 32'd0);

    // Fixed priority with two requesters.
    clear = 1'b1; step(); clear = 1'b0;
    req = (32'h1 << 5) | (32'h1 << 20);
    data[5*32 +: 32] = 32'hDEAD_BEEF;
    step();
    chk("fp_idx", 32'(ifA.grant_idx), 32'd5);
    chk("fp_bus", ifA.bus_out, 32'hDEAD_BEEF);
    chk("fp_cnt", 32'(ifA.conflict_cnt), 32'd1);

    // Round-robin rotation over sources 0, 1, 3.
    clear = 1'b1; step(); clear = 1'b0;
    req = 32'b1011;
    for (int i = 0; i < 6; i++) begin
      step();
      chk("rr_seq", 32'(ifB.grant_idx), 32'(rrSeq[i]));
    end

    // Lock on source 2 while source 0 also requests.
    clear = 1'b1; step(); clear = 1'b0;
    req = 32'b100;
    step();
    lock = 1'b1; req = 32'b101;
    for (int i = 0; i < 3; i++) begin
      data[2*32 +: 32] = 32'hAAAA_0000 + 32'(i);
      step();
      chk("lock_a_idx", 32'(ifA.grant_idx), 32'd2);
      chk("lock_b_bus", ifB.bus_out, 32'hAAAA_0000 + 32'(i));
    end
    req = 32'b001;
    step();
    chk("unlock_a_idx", 32'(ifA.grant_idx), 32'd0);
    chk("unlock_b_idx", 32'(ifB.grant_idx), 32'd0);
    lock = 1'b0;

    // Idle behaviour: A zeroes the bus, B holds it.
    data[31:0] = 32'h1234;
    req = 32'b1; step();
    req = 32'b0; step();
    chk("idle_a_bus", ifA.bus_out, 32'h0);
    chk("idle_b_bus", ifB.bus_out, 32'h1234);
    chk("idle_b_valid", 32'(ifB.bus_valid), 32'h0);

    // Counter saturation and conf_clr priority.
    clear = 1'b1; step(); clear = 1'b0;
    req = 32'b11; checkEn = 1'b0;
    for (int i = 0; i < 65534; i++) step();
    checkEn = 1'b1;
    chk("sat_pre", 32'(ifA.conflict_cnt), 32'hFFFE);
    for (int i = 0; i < 3; i++) step();
    chk("sat_a", 32'(ifA.conflict_cnt), 32'hFFFF);
    chk("sat_b", 32'(ifB.conflict_cnt), 32'hFFFF);
    cclr = 1'b1; step(); cclr = 1'b0;
    chk("cclr_cnt", 32'(ifA.conflict_cnt), 32'h0);
    chk("cclr_flag", 32'(ifB.conflict), 32'h0);

    // Randomized traffic against the model.
    for (int t = 0; t < 600; t++) begin
      r = $urandom_range(0, 3);
      case (r)
        0:       req = 32'h0;
        1:       req = 32'h1 << $urandom_range(0, 31);
        default: req = $urandom() & $urandom();
      endcase
      if ($urandom_range(0, 3) == 0) req[3:0] = 4'($urandom());
      lock  = ($urandom_range(0, 2) == 0);
      cclr  = ($urandom_range(0, 39) == 0);
      clear = ($urandom_range(0, 49) == 0);
      for (int i = 0; i < 32; i++) data[i*32 +: 32] = $urandom();
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/bus_arbiter_mux.md
# bus_arbiter_mux

Registered, parametrised bus source selector for the datapath bus. It replaces the bare select-code mux with a request/grant arbiter. Up to N_SRC sources (registers, HI/LO, Z, PC, MDR, InPort, immediate) raise per-source out-requests. The block chooses one by fixed-priority or round-robin policy, drives the bus from a register, supports multi-cycle bus locking and counts multi-driver conflicts for debug.

## Interface
- N_SRC, 32, number of bus sources (2..32)
- WIDTH, 32, bus data width
- RR_MODE, 0, 0 = fixed priority (lowest index wins), 1 = round-robin
- HOLD_IDLE, 0, 0 = bus_out forced to 0 when no grant, 1 = bus_out holds last driven value
- IDX_W, $clog2(N_SRC), derived width of grant_idx (not overridden)
- clock  in  1  rising-edge clock; single clock domain
- clear  in  1  synchronous, active-high reset
- src_data  in  N_SRC*WIDTH  flattened source data; source i occupies bits [i*WIDTH +: WIDTH]
- src_req  in  N_SRC  per-source request to drive the bus (one bit per "out" strobe)
- bus_lock  in  1  keep current grant while the granted source still requests
- conf_clr  in  1  clear conflict counter
- bus_out  out  WIDTH  registered bus value
- bus_valid  out  1  a grant is active this cycle
- grant  out  N_SRC  one-hot registered grant (all zero when idle)
- grant_idx  out  IDX_W  index of granted source (0 when idle)
- conflict  out  1  sticky: high once any cycle saw more than one request since the last clear/conf_clr
- conflict_cnt  out  16  saturating count of cycles with more than one request

## Operation
- Winner selection is evaluated combinationally from src_req and registered on the clock edge.
- Fixed priority (RR_MODE=0): the lowest-index requesting source wins.
- Round-robin (RR_MODE=1): a pointer ptr (IDX_W bits, reset 0) names the highest-priority index. The search order is ptr, ptr+1, …, N_SRC-1, 0, …, ptr-1. After each grant, ptr = granted index + 1, wrapping N_SRC-1 to 0. ptr is unchanged on idle cycles and on locked cycles.
- Lock: if bus_lock=1, bus_valid=1 and src_req[grant_idx]=1, the grant is retained and other requests are ignored.
  - If the locked source drops its request, normal arbitration resumes that same edge.
  - Lock has no effect when idle.
- Data: on the edge that registers a grant to source k, bus_out <= src_data[k]. While the grant is held by lock, bus_out re-samples src_data[k] every cycle.
- Idle (no request): grant=0, grant_idx=0, bus_valid=0. bus_out = 0 if HOLD_IDLE=0, otherwise the previous value.
- Conflict: each cycle with popcount(src_req)≥2 increments conflict_cnt (saturates at 16'hFFFF) and sets conflict.
  - conf_clr=1 zeroes both counter and flag; conf_clr has priority over an increment in the same cycle.
  - Conflicts are counted regardless of lock.
- The state machine is implicit: IDLE (bus_valid=0) and OWNED(k).
  - IDLE→OWNED(k) on any request.
  - OWNED(k)→OWNED(k) on lock with src_req[k].
  - OWNED(k)→OWNED(j) by arbitration.
  - OWNED→IDLE when no request.
- Request bits at index ≥ N_SRC do not exist. No out-of-range select is possible.

## Timing
- Latency is 1 cycle: requests and data sampled at edge t appear on bus_out/grant/bus_valid after edge t.
- All outputs are registered. There is no combinational path from inputs to outputs.
- Reset: clear=1 at an edge forces bus_out=0, bus_valid=0, grant=0, grant_idx=0, conflict=0, conflict_cnt=0 and ptr=0. clear overrides lock, conf_clr and all requests.
- A mid-transfer clear drops the grant. The first cycle after clear deasserts arbitrates fresh, from ptr=0.
- Back-to-back grants to different sources on consecutive cycles are allowed. There are no dead cycles.

## Test plan
- Reset: drive all src_req=1, clear=1 for 2 cycles -> all outputs 0, conflict_cnt=0; after release, first grant goes to index 0 in both modes.
- Fixed priority: src_req = bits 5 and 20, src_data[5]=32'hDEAD_BEEF -> one cycle later grant_idx=5, bus_out=32'hDEADBEEF, conflict=1, conflict_cnt=1.
- Round-robin with N_SRC=4: requests 0, 1 and 3 held for 6 cycles -> grant_idx sequence is 0,1,3,0,1,3.
- Lock: grant source 2, then bus_lock=1 while source 0 also requests for 3 cycles -> grant stays at 2 and bus_out tracks src_data[2] changes. Drop src_req[2] -> next cycle grant goes to source 0.
- Idle: after a grant with data 32'h1234, remove all requests. HOLD_IDLE=0 gives bus_out=0 and bus_valid=0. HOLD_IDLE=1 holds 32'h1234 with bus_valid=0.
- Counter: preload 65534 conflict cycles, then 3 more -> conflict_cnt=16'hFFFF. conf_clr together with a conflict cycle -> 0.
